fifo_in_ctrl: RTL

Controller for the 8-entry x 32-bit FIFO_IN register bank. Sequences writes by driving the bank's one-hot 8-bit write enable from a circular tail pointer. Reads the selected bank word through a registered read mux at the head pointer, and tracks occupancy. Sits between the requester handshake (wr_en/rd_en) and the register bank, which is fed write data directly from the requester.

---
 rtl/fifo_in_ctrl_if.sv | 54 +++++
 rtl/fifo_in_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_in_ctrl_if.sv
// fifo_in_ctrl_if: requester/bank-side signal bundle for the FIFO_IN controller.
//   master : the requester plus register bank. It drives wr_en, rd_en and
//            bank_q, and observes the bank strobes, read data, flags and acks.
//   slave  : the controller (fifo_in_ctrl).
// Signals:
//   wr_en, rd_en       requests for this cycle
//   bank_q             flattened bank outputs; entry k at [WIDTH*k +: WIDTH]
//   bank_en            one-hot bank write enable (combinational)
//   bank_reset_n       bank reset, active low
//   rd_data            registered read data
//   full, empty, count occupancy state
//   wr_ack/wr_err      outcome of the previous cycle's write request
//   rd_ack/rd_err      outcome of the previous cycle's read request
//   almost_full/_empty present only when FIFO_IN_CTRL_ALMOST_EN is defined
interface fifo_in_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  logic                     wr_en;
  logic                     rd_en;
  logic [WIDTH*DEPTH-1:0]   bank_q;
  logic [DEPTH-1:0]         bank_en;
  logic                     bank_reset_n;
  logic [WIDTH-1:0]         rd_data;
  logic                     full;
  logic                     empty;
  logic [3:0]               count;
  logic                     wr_ack;
  logic                     wr_err;
  logic                     rd_ack;
  logic                     rd_err;
`ifdef FIFO_IN_CTRL_ALMOST_EN
  logic                     almost_full;
  logic                     almost_empty;
`endif

  modport master (
    output wr_en, rd_en, bank_q,
    input  bank_en, bank_reset_n, rd_data, full, empty, count,
           wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_IN_CTRL_ALMOST_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  wr_en, rd_en, bank_q,
    output bank_en, bank_reset_n, rd_data, full, empty, count,
           wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_IN_CTRL_ALMOST_EN
    , output almost_full, almost_empty
`endif
  );
endinterface

// File: rtl/fifo_in_ctrl.sv
// fifo_in_ctrl: controller for the 8-entry FIFO_IN register bank.
// Drives a one-hot bank write strobe from a circular tail pointer, reads the
// bank word at the head pointer through a registered mux, tracks occupancy
// and reports last-cycle request outcomes from a small state register.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    fifo_in_ctrl_if.slave (requests, bank data/strobes, flags, acks)
// Parameters: WIDTH (entry width, default 32), DEPTH (must be 8).
// Optional: define FIFO_IN_CTRL_ALMOST_EN to add almost_full (count>=7) and
// almost_empty (count<=1).
module fifo_in_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  fifo_in_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] WR_ERR   = 3'd2;
  localparam logic [2:0] READ     = 3'd3;
  localparam logic [2:0] RD_ERR   = 3'd4;
  localparam logic [2:0] RW       = 3'd5;
  localparam logic [2:0] WR_RDERR = 3'd6;

  logic [2:0]       head;
  logic [2:0]       tail;
  logic [3:0]       count;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] head_word;
  logic [7:0]       bank_en;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == 4'd8);
  assign empty = (count == 4'd0);

  // A read frees a slot in the same cycle, so a write at full is still
  // accepted when paired with an accepted read.
  assign do_rd = bus.rd_en & ~empty;
  assign do_wr = bus.wr_en & (~full | do_rd);

  always_comb begin
    bank_en = '0;
    if (do_wr && !reset)
      bank_en = 8'd1 << tail;
  end

  always_comb begin
    head_word = '0;
    for (int unsigned k = 0; k < 8; k++)
      if (head == k[2:0])
        head_word = bus.bank_q[k*WIDTH +: WIDTH];
  end

  // Outcome depends only on the requests and the registered flags; full and
  // empty are never both set, so the both-requested branch is unambiguous.
  always_comb begin
    state_nxt = IDLE;
    case ({bus.wr_en, bus.rd_en})
      2'b10:   state_nxt = full  ? WR_ERR   : WRITE;
      2'b01:   state_nxt = empty ? RD_ERR   : READ;
      2'b11:   state_nxt = empty ? WR_RDERR : RW;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rd_data_q <= '0;
      state     <= IDLE;
    end else begin
      state <= state_nxt;
      if (do_wr)
        tail <= tail + 3'd1;
      if (do_rd) begin
        head      <= head + 3'd1;
        rd_data_q <= head_word;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.bank_en      = bank_en;
  assign bus.bank_reset_n = ~reset;
  assign bus.rd_data      = rd_data_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.wr_ack       = (state == WRITE) || (state == RW) || (state == WR_RDERR);
  assign bus.wr_err       = (state == WR_ERR);
  assign bus.rd_ack       = (state == READ) || (state == RW);
  assign bus.rd_err       = (state == RD_ERR) || (state == WR_RDERR);
`ifdef FIFO_IN_CTRL_ALMOST_EN
  assign bus.almost_full  = (count >= 4'd7);
  assign bus.almost_empty = (count <= 4'd1);
`endif

endmodule
